// File: rtl/comm_tx_scheduler.sv
// rtl/comm_tx_scheduler.sv - message request arbiter and new-game reliability sequencer
//
// Collects ball / miss / new_game / new_game_ack requests, latches their payloads,
// grants the single CommunicationSender one message at a time (ack > new_game >
// miss > ball) and runs the send_new_message / message_sent handshake. After a
// new_game message it waits for the peer ack, retransmits on timeout and flags
// link_error once the retries are exhausted.
//
// Ports
//   clock, reset                 clock and asynchronous active-low reset
//   ball_req + ball payload      ball message request (ball_y_in, velocity_x_in, velocity_y_in)
//   miss_req + miss payload      miss message request (my_score_in, your_score_in, you_should_serve_in)
//   new_game_req                 start / restart the new-game exchange (you_serve_first_in)
//   ack_req                      send a new_game_ack message
//   new_game_ack_seen            peer ack decoded by the receive side
//   send_new_message             request to the sender, held until message_sent
//   message_sent                 sender accepted the current message
//   *_message_tx                 one-hot message type, high only with send_new_message
//   *_tx payload                 payload of the granted message
//   busy, link_up, link_error    status

module comm_tx_scheduler #(
   parameter int ACK_TIMEOUT = 5_000_000,
   parameter int MAX_RETRIES = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ball_req,
   input  logic [8:0] ball_y_in,
   input  logic [3:0] velocity_x_in,
   input  logic [3:0] velocity_y_in,
   input  logic       miss_req,
   input  logic [4:0] my_score_in,
   input  logic [4:0] your_score_in,
   input  logic       you_should_serve_in,
   input  logic       new_game_req,
   input  logic       you_serve_first_in,
   input  logic       ack_req,
   input  logic       new_game_ack_seen,
   output logic       send_new_message,
   input  logic       message_sent,
   output logic       ball_message_tx,
   output logic       miss_message_tx,
   output logic       new_game_message_tx,
   output logic       new_game_ack_message_tx,
   output logic [8:0] ball_y_tx,
   output logic [3:0] velocity_x_tx,
   output logic [3:0] velocity_y_tx,
   output logic [4:0] my_score_tx,
   output logic [4:0] your_score_tx,
   output logic       you_should_serve_tx,
   output logic       you_serve_first_tx,
   output logic       busy,
   output logic       link_up,
   output logic       link_error
);

   localparam int TW = $clog2(ACK_TIMEOUT);
   localparam int RW = $clog2(MAX_RETRIES + 2);
   localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SEND     = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_SEND_ACK = 3'd3;
   localparam logic [2:0] S_ERROR    = 3'd4;

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry;
   logic          ret_err;   // SEND_ACK was entered from ERROR rather than WAIT_ACK

   logic ball_pend, miss_pend, ng_pend, ack_pend;
   logic [8:0] ball_y_l;
   logic [3:0] vx_l, vy_l;
   logic [4:0] my_l, your_l;
   logic       serve_l, first_l;

   logic go_ball, go_miss, go_ng, go_ack_idle, go_ack_wait, go_ack_err;
   logic abort, acked, acked_in_flight, timeout, resend, give_up, launch_ack;

   always_comb begin
      go_ball         = 1'b0;
      go_miss         = 1'b0;
      go_ng           = 1'b0;
      go_ack_idle     = 1'b0;
      go_ack_wait     = 1'b0;
      go_ack_err      = 1'b0;
      abort           = 1'b0;
      acked           = 1'b0;
      acked_in_flight = 1'b0;
      timeout         = 1'b0;
      case (state)
         S_IDLE: begin
            go_ack_idle = ack_pend;
            go_ng       = !ack_pend && ng_pend;
            // ball/miss wait for an established link instead of being dropped
            go_miss     = !ack_pend && !ng_pend && link_up && miss_pend;
            go_ball     = !ack_pend && !ng_pend && link_up && !miss_pend && ball_pend;
         end
         S_WAIT_ACK: begin
            abort       = ng_pend;
            acked       = !ng_pend && new_game_ack_seen;
            go_ack_wait = !ng_pend && !new_game_ack_seen && ack_pend;
            timeout     = !ng_pend && !new_game_ack_seen && !ack_pend && (timer >= T_LAST);
         end
         S_SEND_ACK: acked_in_flight = !ret_err && new_game_ack_seen;
         S_ERROR: begin
            abort      = ng_pend;
            go_ack_err = !ng_pend && ack_pend;
         end
         default: ;
      endcase
   end

   assign resend     = timeout && (retry < R_MAX);
   assign give_up    = timeout && !(retry < R_MAX);
   assign launch_ack = go_ack_idle || go_ack_wait || go_ack_err;
   assign busy       = (state != S_IDLE) || ball_pend || miss_pend || ng_pend || ack_pend;

   // Request capture: a request on the launch edge wins over the clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ball_pend <= 1'b0;
         miss_pend <= 1'b0;
         ng_pend   <= 1'b0;
         ack_pend  <= 1'b0;
         ball_y_l  <= '0;
         vx_l      <= '0;
         vy_l      <= '0;
         my_l      <= '0;
         your_l    <= '0;
         serve_l   <= 1'b0;
         first_l   <= 1'b0;
      end else begin
         ball_pend <= ball_req     || (ball_pend && !go_ball);
         miss_pend <= miss_req     || (miss_pend && !go_miss);
         ng_pend   <= new_game_req || (ng_pend && !go_ng);
         ack_pend  <= ack_req      || (ack_pend && !launch_ack);
         if (ball_req) begin
            ball_y_l <= ball_y_in;
            vx_l     <= velocity_x_in;
            vy_l     <= velocity_y_in;
         end
         if (miss_req) begin
            my_l    <= my_score_in;
            your_l  <= your_score_in;
            serve_l <= you_should_serve_in;
         end
         if (new_game_req) first_l <= you_serve_first_in;
      end
   end

   // Link status, retry count and ack timer; a new_game_req restarts all of them.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         link_up    <= 1'b0;
         link_error <= 1'b0;
         retry      <= '0;
         timer      <= '0;
      end else if (new_game_req) begin
         link_up    <= 1'b0;
         link_error <= 1'b0;
         retry      <= '0;
         timer      <= '0;
      end else begin
         if (acked || acked_in_flight) link_up <= 1'b1;
         if (give_up) link_error <= 1'b1;
         if (resend) retry <= retry + RW'(1);
         if (state == S_SEND && message_sent && new_game_message_tx)
            timer <= '0;
         else if ((state == S_WAIT_ACK || (state == S_SEND_ACK && !ret_err)) && timer != T_LAST)
            timer <= timer + TW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                   <= S_IDLE;
         ret_err                 <= 1'b0;
         send_new_message        <= 1'b0;
         ball_message_tx         <= 1'b0;
         miss_message_tx         <= 1'b0;
         new_game_message_tx     <= 1'b0;
         new_game_ack_message_tx <= 1'b0;
         ball_y_tx               <= '0;
         velocity_x_tx           <= '0;
         velocity_y_tx           <= '0;
         my_score_tx             <= '0;
         your_score_tx           <= '0;
         you_should_serve_tx     <= 1'b0;
         you_serve_first_tx      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go_ack_idle || go_ng || go_miss || go_ball) begin
                  state                   <= S_SEND;
                  send_new_message        <= 1'b1;
                  new_game_ack_message_tx <= go_ack_idle;
                  new_game_message_tx     <= go_ng;
                  miss_message_tx         <= go_miss;
                  ball_message_tx         <= go_ball;
               end
               if (go_ng) you_serve_first_tx <= first_l;
               if (go_miss) begin
                  my_score_tx         <= my_l;
                  your_score_tx       <= your_l;
                  you_should_serve_tx <= serve_l;
               end
               if (go_ball) begin
                  ball_y_tx     <= ball_y_l;
                  velocity_x_tx <= vx_l;
                  velocity_y_tx <= vy_l;
               end
            end
            S_SEND: begin
               if (message_sent) begin
                  state                   <= new_game_message_tx ? S_WAIT_ACK : S_IDLE;
                  send_new_message        <= 1'b0;
                  ball_message_tx         <= 1'b0;
                  miss_message_tx         <= 1'b0;
                  new_game_message_tx     <= 1'b0;
                  new_game_ack_message_tx <= 1'b0;
               end
            end
            S_WAIT_ACK: begin
               if (abort || acked) begin
                  state <= S_IDLE;
               end else if (go_ack_wait) begin
                  state                   <= S_SEND_ACK;
                  ret_err                 <= 1'b0;
                  send_new_message        <= 1'b1;
                  new_game_ack_message_tx <= 1'b1;
               end else if (resend) begin
                  state               <= S_SEND;
                  send_new_message    <= 1'b1;
                  new_game_message_tx <= 1'b1;
                  you_serve_first_tx  <= first_l;
               end else if (give_up) begin
                  state <= S_ERROR;
               end
            end
            S_SEND_ACK: begin
               if (message_sent) begin
                  send_new_message        <= 1'b0;
                  new_game_ack_message_tx <= 1'b0;
                  if (ret_err)
                     state <= S_ERROR;
                  else if (link_up || acked_in_flight)
                     state <= S_IDLE;
                  else
                     state <= S_WAIT_ACK;
               end
            end
            S_ERROR: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (go_ack_err) begin
                  state                   <= S_SEND_ACK;
                  ret_err                 <= 1'b1;
                  send_new_message        <= 1'b1;
                  new_game_ack_message_tx <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comm_tx_scheduler.sv
// tb/tb_comm_tx_scheduler.sv - self-checking bench for comm_tx_scheduler

module tb_comm_tx_scheduler;

   localparam int TO = 16;
   localparam int MR = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ball_req = 0, miss_req = 0, new_game_req = 0, ack_req = 0, new_game_ack_seen = 0;
   logic [8:0] ball_y_in = '0;
   logic [3:0] velocity_x_in = '0, velocity_y_in = '0;
   logic [4:0] my_score_in = '0, your_score_in = '0;
   logic       you_should_serve_in = 0, you_serve_first_in = 0, message_sent = 0;
   logic       send_new_message, ball_message_tx, miss_message_tx, new_game_message_tx, new_game_ack_message_tx;
   logic [8:0] ball_y_tx;
   logic [3:0] velocity_x_tx, velocity_y_tx;
   logic [4:0] my_score_tx, your_score_tx;
   logic       you_should_serve_tx, you_serve_first_tx, busy, link_up, link_error;

   always #5 clock = ~clock;

   comm_tx_scheduler #(.ACK_TIMEOUT(TO), .MAX_RETRIES(MR)) dut (
      .clock(clock), .reset(reset),
      .ball_req(ball_req), .ball_y_in(ball_y_in), .velocity_x_in(velocity_x_in), .velocity_y_in(velocity_y_in),
      .miss_req(miss_req), .my_score_in(my_score_in), .your_score_in(your_score_in),
      .you_should_serve_in(you_should_serve_in),
      .new_game_req(new_game_req), .you_serve_first_in(you_serve_first_in),
      .ack_req(ack_req), .new_game_ack_seen(new_game_ack_seen),
      .send_new_message(send_new_message), .message_sent(message_sent),
      .ball_message_tx(ball_message_tx), .miss_message_tx(miss_message_tx),
      .new_game_message_tx(new_game_message_tx), .new_game_ack_message_tx(new_game_ack_message_tx),
      .ball_y_tx(ball_y_tx), .velocity_x_tx(velocity_x_tx), .velocity_y_tx(velocity_y_tx),
      .my_score_tx(my_score_tx), .your_score_tx(your_score_tx),
      .you_should_serve_tx(you_should_serve_tx), .you_serve_first_tx(you_serve_first_tx),
      .busy(busy), .link_up(link_up), .link_error(link_error)
   );

   // message types: 0 ball, 1 miss, 2 new_game, 3 ack
   typedef struct {
      int          typ;
      int          cyc;
      int          gap;
      logic [16:0] bpl;
      logic [10:0] mpl;
      logic        sf;
   } msg_t;

   msg_t        sent_q[$];
   int          n_cmp = 0, n_bad = 0;
   int          cyc = 0, hold = 0, lowcnt = 0, last_hold = 0, delay_cfg = 1, cur_delay = 1;
   bit          spurious_en = 0;
   logic        prev_snm = 0;
   logic [32:0] snap;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int stype();
      if (new_game_ack_message_tx) return 3;
      if (new_game_message_tx) return 2;
      if (miss_message_tx) return 1;
      if (ball_message_tx) return 0;
      return -1;
   endfunction

   function automatic logic [32:0] outvec();
      return {ball_message_tx, miss_message_tx, new_game_message_tx, new_game_ack_message_tx,
              ball_y_tx, velocity_x_tx, velocity_y_tx, my_score_tx, your_score_tx,
              you_should_serve_tx, you_serve_first_tx};
   endfunction

   // One cycle: observe at the falling edge, play the sender, clear request pulses.
   task automatic tick();
      msg_t m;
      @(negedge clock);
      cyc++;
      ball_req = 0; miss_req = 0; new_game_req = 0; ack_req = 0; new_game_ack_seen = 0;
      check("one_hot", 64'(ball_message_tx) + 64'(miss_message_tx) + 64'(new_game_message_tx)
            + 64'(new_game_ack_message_tx), 64'(send_new_message));
      if (send_new_message) begin
         if (!prev_snm) begin
            hold      = 1;
            cur_delay = (delay_cfg == 0) ? int'($urandom_range(1, 4)) : delay_cfg;
            m.typ = stype(); m.cyc = cyc; m.gap = lowcnt;
            m.bpl = {ball_y_tx, velocity_x_tx, velocity_y_tx};
            m.mpl = {my_score_tx, your_score_tx, you_should_serve_tx};
            m.sf  = you_serve_first_tx;
            sent_q.push_back(m);
            snap = outvec();
         end else begin
            hold++;
            check("held_stable", 64'(outvec()), 64'(snap));
         end
         message_sent = (hold == cur_delay);
      end else begin
         if (prev_snm) begin
            last_hold = hold;
            lowcnt    = 1;
         end else begin
            lowcnt++;
         end
         message_sent = spurious_en && ($urandom_range(0, 3) == 0);
      end
      prev_snm = send_new_message;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_sent(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && sent_q.size() < n; i++) tick();
      check(tag, 64'(sent_q.size()), 64'(n));
   endtask

   task automatic pop(output msg_t m);
      if (sent_q.size() > 0) m = sent_q.pop_front();
      else begin m.typ = -1; m.cyc = 0; m.gap = 0; m.bpl = '0; m.mpl = '0; m.sf = 0; end
   endtask

   task automatic wait_fall();
      for (int i = 0; i < 30 && send_new_message; i++) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      msg_t        m;
      int          req_cyc, exp_t;
      bit          m_ball, m_miss, m_ack, d_ball, d_miss, d_ack;
      logic [16:0] m_bpl, d_bpl;
      logic [10:0] m_mpl, d_mpl;

      // reset state
      run(3);
      check("rst_snm", 64'(send_new_message), 0);
      check("rst_strobes", 64'(outvec()), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_link", 64'({link_up, link_error}), 0);
      reset = 1;
      run(2);

      // new game handshake, sender accepts after 3 cycles, ack 10 cycles later
      delay_cfg = 3;
      you_serve_first_in = 1; new_game_req = 1; req_cyc = cyc;
      wait_sent("t1_sent", 1, 10);
      pop(m);
      check("t1_type", 64'(m.typ), 2);
      check("t1_sf", 64'(m.sf), 1);
      check("t1_latency", 64'(m.cyc - req_cyc), 2);
      wait_fall();
      check("t1_hold", 64'(last_hold), 3);
      check("t1_busy_wait", 64'(busy), 1);
      check("t1_link_before", 64'(link_up), 0);
      for (int i = 0; i < 20 && lowcnt < 10; i++) tick();
      new_game_ack_seen = 1;
      tick();
      check("t1_link_up", 64'(link_up), 1);
      check("t1_idle", 64'(busy), 0);

      // simultaneous ball + miss + ack: ack, miss, ball
      delay_cfg = 2;
      ball_y_in = 9'd300; velocity_x_in = 4'd5; velocity_y_in = 4'hD;
      my_score_in = 5'd7; your_score_in = 5'd12; you_should_serve_in = 1;
      ball_req = 1; miss_req = 1; ack_req = 1;
      wait_sent("t2_sent", 3, 60);
      pop(m); check("t2_first", 64'(m.typ), 3);
      pop(m); check("t2_second", 64'(m.typ), 1);
      check("t2_miss_pl", 64'(m.mpl), 64'({5'd7, 5'd12, 1'b1}));
      pop(m); check("t2_third", 64'(m.typ), 0);
      check("t2_ball_pl", 64'(m.bpl), 64'({9'd300, 4'd5, 4'hD}));
      run(5);

      // two ball requests during a busy send: one ball send, latest payload
      delay_cfg = 6;
      ack_req = 1;
      tick(); tick();
      ball_req = 1; ball_y_in = 9'd100; velocity_x_in = 4'd3; velocity_y_in = 4'd4;
      tick(); tick();
      ball_req = 1; ball_y_in = 9'd200;
      wait_sent("t3_sent", 2, 40);
      pop(m); check("t3_ack", 64'(m.typ), 3);
      pop(m); check("t3_ball", 64'(m.typ), 0);
      check("t3_ball_pl", 64'(m.bpl), 64'({9'd200, 4'd3, 4'd4}));
      run(20);
      check("t3_no_extra", 64'(sent_q.size()), 0);

      // randomized traffic with link up, against a pending-set model
      delay_cfg = 0; spurious_en = 1;
      m_ball = 0; m_miss = 0; m_ack = 0; d_ball = 0; d_miss = 0; d_ack = 0;
      m_bpl = '0; m_mpl = '0; d_bpl = '0; d_mpl = '0;
      for (int it = 0; it < 600; it++) begin
         tick();
         while (sent_q.size() > 0) begin
            pop(m);
            exp_t = m_ack ? 3 : m_miss ? 1 : m_ball ? 0 : -1;
            check("rnd_type", 64'(m.typ), 64'(exp_t));
            if (exp_t == 1) check("rnd_miss_pl", 64'(m.mpl), 64'(m_mpl));
            if (exp_t == 0) check("rnd_ball_pl", 64'(m.bpl), 64'(m_bpl));
            if (exp_t == 3) m_ack = 0;
            if (exp_t == 1) m_miss = 0;
            if (exp_t == 0) m_ball = 0;
         end
         if (d_ball) begin m_ball = 1; m_bpl = d_bpl; end
         if (d_miss) begin m_miss = 1; m_mpl = d_mpl; end
         if (d_ack) m_ack = 1;
         ball_y_in = 9'($urandom); velocity_x_in = 4'($urandom); velocity_y_in = 4'($urandom);
         my_score_in = 5'($urandom); your_score_in = 5'($urandom); you_should_serve_in = 1'($urandom);
         d_ball = (it < 550) && ($urandom_range(0, 5) == 0);
         d_miss = (it < 550) && ($urandom_range(0, 7) == 0);
         d_ack  = (it < 550) && ($urandom_range(0, 9) == 0);
         d_bpl = {ball_y_in, velocity_x_in, velocity_y_in};
         d_mpl = {my_score_in, your_score_in, you_should_serve_in};
         ball_req = d_ball; miss_req = d_miss; ack_req = d_ack;
         new_game_ack_seen = ($urandom_range(0, 15) == 0);
      end
      spurious_en = 0;
      check("rnd_drained", 64'({m_ack, m_miss, m_ball}), 0);
      check("rnd_busy", 64'(busy), 0);
      check("rnd_link", 64'(link_up), 1);

      // no ack: first send plus MR retries TO cycles apart, then link_error
      delay_cfg = 1;
      you_serve_first_in = 0; new_game_req = 1;
      for (int i = 0; i < 150 && !link_error; i++) tick();
      check("t4_link_error", 64'(link_error), 1);
      check("t4_sends", 64'(sent_q.size()), MR + 1);
      for (int k = 0; k <= MR; k++) begin
         pop(m);
         check("t4_type", 64'(m.typ), 2);
         check("t4_sf", 64'(m.sf), 0);
         if (k > 0) check("t4_gap", 64'(m.gap), TO);
      end
      run(40);
      check("t4_silent_err", 64'(sent_q.size()), 0);

      // restart clears link_error; ack on the timeout edge wins; ball held until link_up
      you_serve_first_in = 1; new_game_req = 1;
      tick();
      check("t5_err_clear", 64'(link_error), 0);
      ball_req = 1; ball_y_in = 9'd77; velocity_x_in = 4'd1; velocity_y_in = 4'd2;
      wait_sent("t5_ng_sent", 1, 10);
      pop(m);
      check("t5_type", 64'(m.typ), 2);
      check("t5_sf", 64'(m.sf), 1);
      wait_fall();
      for (int i = 0; i < 30 && lowcnt < TO; i++) tick();
      check("t5_ball_held", 64'(sent_q.size()), 0);
      new_game_ack_seen = 1;
      tick();
      check("t5_link_up", 64'(link_up), 1);
      wait_sent("t5_ball_sent", 1, 10);
      pop(m);
      check("t5_ball", 64'(m.typ), 0);
      check("t5_ball_pl", 64'(m.bpl), 64'({9'd77, 4'd1, 4'd2}));
      run(40);
      check("t5_no_resend", 64'(sent_q.size()), 0);

      // reset in the middle of a send
      delay_cfg = 10;
      ball_req = 1; ball_y_in = 9'd55;
      for (int i = 0; i < 10 && !send_new_message; i++) tick();
      miss_req = 1;
      tick();
      #2 reset = 0;
      #1;
      check("t6_snm", 64'(send_new_message), 0);
      check("t6_outputs", 64'(outvec()), 0);
      check("t6_busy", 64'(busy), 0);
      check("t6_link", 64'({link_up, link_error}), 0);
      message_sent = 0; prev_snm = 0; hold = 0;
      sent_q.delete();
      tick();
      reset = 1;
      run(20);
      check("t6_no_send", 64'(sent_q.size()), 0);
      check("t6_busy_after", 64'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
